// File: rtl/mp_irq_pkg.sv
// Shared types for the mp_irq generator/receiver pair: FSM state encoding,
// counter widths and the effective-width helper.
package mp_irq_pkg;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [2:0] {
    IDLE_ST    = 3'd0,
    QUALIFY_ST = 3'd1,
    PENDING_ST = 3'd2,
    RETRY_ST   = 3'd3,
    ERROR_ST   = 3'd4
  } irq_state_e;

  // A zero MIN_WIDTH falls back to the elaboration-time default.
  function automatic logic [CNT_W-1:0] eff_width(input logic [CNT_W-1:0] min_width,
                                                 input logic [CNT_W-1:0] dflt);
    if (min_width == {CNT_W{1'b0}}) begin
      return dflt;
    end else begin
      return min_width;
    end
  endfunction

endpackage

// File: rtl/mp_irq_edge_detect.sv
// Two-stage sampler for a same-clock input: registered copy of the line plus
// a one-cycle rising-edge pulse derived from it.
module mp_irq_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sig_s,
  output logic rise_s
);

  logic samp_d;
  logic samp_q;
  logic samp_dly_q;

  always_comb begin
    samp_d = sig_in;
  end

  // Sample register and its one-cycle-delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q     <= RESET_VAL;
      samp_dly_q <= RESET_VAL;
    end else begin
      samp_q     <= samp_d;
      samp_dly_q <= samp_q;
    end
  end

  assign sig_s  = samp_q;
  assign rise_s = samp_q & ~samp_dly_q;

endmodule

// File: rtl/mp_irq_receiver.sv
// Receiving end of the mp_irq interrupt line: width qualification, pending
// flag held until acknowledge, timeout-driven retry requests and error state.
module mp_irq_receiver
  import mp_irq_pkg::*;
#(
  parameter int unsigned DEFAULT_MIN_WIDTH = 1
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               IRQ_IN,
  input  logic               IRQ_ACK,
  input  logic [CNT_W-1:0]   MIN_WIDTH,
  input  logic [CNT_W-1:0]   TIMEOUT,
  input  logic [RETRY_W-1:0] RETRY_LIMIT,
  output logic               RETRY,
  output logic               IRQ_PENDING,
  output logic               ERROR,
  output logic [CNT_W-1:0]   IRQ_COUNT
);

  irq_state_e         state_d, state_q;
  logic [CNT_W-1:0]   width_cnt_d, width_cnt_q;
  logic [CNT_W-1:0]   tmo_cnt_d, tmo_cnt_q;
  logic [RETRY_W-1:0] retry_cnt_d, retry_cnt_q;
  logic [CNT_W-1:0]   irq_count_d, irq_count_q;
  logic               retry_d, retry_q;
  logic               pending_d, pending_q;
  logic               error_d, error_q;
  logic               irq_s;
  logic               rise_s;
  logic [CNT_W-1:0]   width_s;
  logic               pend_entry_s;
  logic               tmo_hit_s;

  mp_irq_edge_detect #(.RESET_VAL(1'b0)) u_edge (
    .clk    (CLK),
    .rst_n  (RESETN),
    .sig_in (IRQ_IN),
    .sig_s  (irq_s),
    .rise_s (rise_s)
  );

  assign width_s      = eff_width(MIN_WIDTH, CNT_W'(DEFAULT_MIN_WIDTH));
  assign tmo_hit_s    = (TIMEOUT != {CNT_W{1'b0}}) && (tmo_cnt_q == TIMEOUT - 32'd1);
  assign pend_entry_s = (state_d == PENDING_ST) && (state_q != PENDING_ST);

  // Next-state logic; ACK takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ST: begin
        if (rise_s) begin
          state_d = (width_s <= 32'd1) ? PENDING_ST : QUALIFY_ST;
        end else begin
          state_d = IDLE_ST;
        end
      end
      QUALIFY_ST: begin
        if (!irq_s) begin
          state_d = IDLE_ST;
        end else if (width_cnt_q == width_s - 32'd1) begin
          state_d = PENDING_ST;
        end else begin
          state_d = QUALIFY_ST;
        end
      end
      PENDING_ST: begin
        if (IRQ_ACK) begin
          state_d = IDLE_ST;
        end else if (tmo_hit_s) begin
          state_d = (retry_cnt_q < RETRY_LIMIT) ? RETRY_ST : ERROR_ST;
        end else begin
          state_d = PENDING_ST;
        end
      end
      RETRY_ST: state_d = IDLE_ST;
      ERROR_ST: begin
        if (IRQ_ACK) begin
          state_d = IDLE_ST;
        end else begin
          state_d = ERROR_ST;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Counter next values, decoded from current and next state.
  always_comb begin
    width_cnt_d = width_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_cnt_d = retry_cnt_q;
    irq_count_d = irq_count_q;
    if (state_q == IDLE_ST && rise_s) begin
      width_cnt_d = 32'd1;
    end else if (state_q == QUALIFY_ST && irq_s) begin
      width_cnt_d = width_cnt_q + 32'd1;
    end else begin
      width_cnt_d = width_cnt_q;
    end
    if (pend_entry_s) begin
      tmo_cnt_d   = 32'd0;
      irq_count_d = irq_count_q + 32'd1;
    end else if (state_q == PENDING_ST && state_d == PENDING_ST) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
    if (state_q == RETRY_ST) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end else if ((state_q == PENDING_ST || state_q == ERROR_ST) && IRQ_ACK) begin
      retry_cnt_d = 8'd0;
    end else begin
      retry_cnt_d = retry_cnt_q;
    end
  end

  // Output flags are registered copies of the next-state decode.
  always_comb begin
    retry_d   = (state_d == RETRY_ST);
    pending_d = (state_d == PENDING_ST);
    error_d   = (state_d == ERROR_ST);
  end

  // State, counter and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE_ST;
      width_cnt_q <= 32'd0;
      tmo_cnt_q   <= 32'd0;
      retry_cnt_q <= 8'd0;
      irq_count_q <= 32'd0;
      retry_q     <= 1'b0;
      pending_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_cnt_q <= width_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      irq_count_q <= irq_count_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      error_q     <= error_d;
    end
  end

  assign RETRY       = retry_q;
  assign IRQ_PENDING = pending_q;
  assign ERROR       = error_q;
  assign IRQ_COUNT   = irq_count_q;

endmodule

// File: tb/tb_mp_irq_receiver.sv
// Directed self-checking bench for mp_irq_receiver; the generator's re-issue
// on RETRY is emulated by driving a fresh IRQ_IN pulse.
module tb_mp_irq_receiver;

  logic        clk;
  logic        rstn;
  logic        irq_in;
  logic        irq_ack;
  logic [31:0] min_width;
  logic [31:0] timeout;
  logic [7:0]  retry_limit;
  logic        retry;
  logic        irq_pending;
  logic        error;
  logic [31:0] irq_count;

  int n_checks = 0;
  int n_pass   = 0;

  mp_irq_receiver #(.DEFAULT_MIN_WIDTH(1)) dut (
    .CLK         (clk),
    .RESETN      (rstn),
    .IRQ_IN      (irq_in),
    .IRQ_ACK     (irq_ack),
    .MIN_WIDTH   (min_width),
    .TIMEOUT     (timeout),
    .RETRY_LIMIT (retry_limit),
    .RETRY       (retry),
    .IRQ_PENDING (irq_pending),
    .ERROR       (error),
    .IRQ_COUNT   (irq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // IRQ_IN high for n sampling edges, starting at the next edge.
  task automatic pulse(input int n);
    irq_in = 1'b1;
    repeat (n) step();
    irq_in = 1'b0;
  endtask

  initial begin
    int seen;
    int lost;
    rstn = 1'b0; irq_in = 1'b0; irq_ack = 1'b0;
    min_width = 32'd4; timeout = 32'd10; retry_limit = 8'd2;
    #2;
    check("rst_pending", irq_pending, 1'b0);
    check("rst_retry", retry, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_count", irq_count, 32'd0);
    repeat (2) step();
    rstn = 1'b1;
    step();

    // Glitch of 3 cycles against a width of 4
    pulse(3);
    seen = 0;
    repeat (8) begin step(); if (irq_pending) seen++; end
    check("glitch_pend", seen, 0);
    check("glitch_count", irq_count, 32'd0);

    // Qualified pulse: pending exactly at k+4
    pulse(4);
    check("qual_early", irq_pending, 1'b0);
    step();
    check("qual_edge", irq_pending, 1'b1);
    check("qual_count", irq_count, 32'd1);

    // ACK 5 cycles after pending with TIMEOUT=10
    repeat (4) step();
    check("ack_hold", irq_pending, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("ack_exit", irq_pending, 1'b0);
    seen = 0;
    repeat (15) begin step(); if (retry) seen++; end
    check("ack_noretry", seen, 0);

    // Retry loop: TIMEOUT=8, RETRY_LIMIT=2, no ACK
    timeout = 32'd8;
    pulse(4); step();
    for (int r = 0; r < 3; r++) begin
      check("loop_count", irq_count, 32'd2 + 32'(r));
      repeat (7) step();
      check("tmo_hold", irq_pending, 1'b1);
      step();
      if (r < 2) begin
        check("retry_hi", retry, 1'b1);
        check("retry_pend", irq_pending, 1'b0);
        step();
        check("retry_width", retry, 1'b0);
        pulse(4); step();
        check("reissue_pend", irq_pending, 1'b1);
      end else begin
        check("err_hi", error, 1'b1);
        check("err_noretry", retry, 1'b0);
      end
    end
    check("loop_total", irq_count, 32'd4);
    repeat (5) step();
    check("err_held", error, 1'b1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("err_ack", error, 1'b0);

    // ACK on the exact expiry edge wins
    timeout = 32'd6;
    pulse(4); step();
    repeat (5) step();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("tie_pend", irq_pending, 1'b0);
    check("tie_retry", retry, 1'b0);
    check("tie_error", error, 1'b0);
    step();
    check("tie_retry2", retry, 1'b0);
    check("tie_count", irq_count, 32'd5);

    // Retry counter was cleared by the earlier ACK: a retry, not an error
    pulse(4); step();
    repeat (6) step();
    check("retry_cleared", retry, 1'b1);
    check("retry_cleared_err", error, 1'b0);
    step();

    // TIMEOUT=0 holds pending; second pulse is coalesced
    timeout = 32'd0;
    pulse(4); step();
    check("hold_count", irq_count, 32'd7);
    pulse(6); step();
    check("coalesce", irq_count, 32'd7);
    seen = 0; lost = 0;
    repeat (1000) begin
      step();
      if (retry) seen++;
      if (!irq_pending) lost++;
    end
    check("hold_noretry", seen, 0);
    check("hold_pending", lost, 0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("hold_ack", irq_pending, 1'b0);

    // MIN_WIDTH=0 selects the default width of 1
    min_width = 32'd0;
    pulse(1);
    check("dflt_early", irq_pending, 1'b0);
    step();
    check("dflt_pend", irq_pending, 1'b1);
    check("dflt_count", irq_count, 32'd8);

    // Asynchronous reset between edges while pending
    #3;
    rstn = 1'b0;
    #1;
    check("arst_pend", irq_pending, 1'b0);
    check("arst_count", irq_count, 32'd0);
    check("arst_retry", retry, 1'b0);
    check("arst_error", error, 1'b0);
    step(); step();
    rstn = 1'b1;
    step();
    check("post_rst_count", irq_count, 32'd0);
    check("post_rst_pend", irq_pending, 1'b0);

    // RETRY_LIMIT=0: first timeout goes straight to error
    min_width = 32'd4; timeout = 32'd3; retry_limit = 8'd0;
    pulse(4); step();
    check("lim0_pend", irq_pending, 1'b1);
    check("lim0_count", irq_count, 32'd1);
    repeat (3) step();
    check("lim0_err", error, 1'b1);
    check("lim0_retry", retry, 1'b0);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check("lim0_ack", error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_irq_receiver.md
# mp_irq_receiver

Receiving end of the `mp_irq_generator` interrupt line.
- Qualifies incoming IRQ pulses by minimum width and holds a pending flag until software acknowledges it.
- On acknowledge timeout, requests a re-issue from the generator through its `RETRY` input, up to a retry limit.
- Sits between the generator's `USER_EVENT_OUT` and the register/CPU side. It shares the generator's clock.

## Interface
Parameters:
- `DEFAULT_MIN_WIDTH`, 1: value used for the width threshold while `MIN_WIDTH` input is 0.

Ports:
- `CLK`  in  1  system clock; all logic on rising edge.
- `RESETN`  in  1  asynchronous, active-low reset; one clock.
- `IRQ_IN`  in  1  interrupt line from generator `USER_EVENT_OUT`, same clock domain.
- `IRQ_ACK`  in  1  software acknowledge, level, sampled each edge.
- `MIN_WIDTH`  in  32  cycles `IRQ_IN` must stay high to qualify; 0 selects `DEFAULT_MIN_WIDTH`.
- `TIMEOUT`  in  32  cycles in PENDING before retry; 0 disables timeout.
- `RETRY_LIMIT`  in  8  maximum consecutive retries before ERROR.
- `RETRY`  out  1  one-cycle pulse to generator `RETRY`.
- `IRQ_PENDING`  out  1  qualified interrupt awaiting ACK.
- `ERROR`  out  1  retries exhausted; held until ACK.
- `IRQ_COUNT`  out  32  qualified interrupts since reset.

## Operation
Input sampling:
- `irq_s` is `IRQ_IN` registered once.
- `rise = irq_s & ~irq_s_d`.

Internal state:
- `width_cnt`, 32 bit.
- `tmo_cnt`, 32 bit.
- `retry_cnt`, 8 bit.
- `IRQ_COUNT` is a 32-bit counter that wraps 0xFFFFFFFF -> 0.

State machine:
- IDLE:
  - `rise` with effective width ≤1 -> PENDING.
  - `rise` with effective width >1 -> QUALIFY with `width_cnt`=1.
  - `IRQ_ACK` is ignored.
- QUALIFY:
  - `irq_s` low -> IDLE. The pulse is discarded as a glitch and not counted.
  - Otherwise increment `width_cnt`.
  - When `width_cnt == width-1` and `irq_s` is high -> PENDING.
- PENDING:
  - On every entry: `IRQ_COUNT++` and `tmo_cnt`=0.
  - `IRQ_ACK` -> IDLE and `retry_cnt`=0.
  - Else, if `TIMEOUT != 0` and `tmo_cnt == TIMEOUT-1`:
    - `retry_cnt < RETRY_LIMIT` -> RETRY_ST.
    - Otherwise -> ERROR_ST.
  - Else `tmo_cnt++`.
  - Further `rise` events in PENDING are coalesced: not counted, no effect.
- RETRY_ST: one cycle, `retry_cnt++`, -> IDLE to await the re-issued pulse.
- ERROR_ST: `IRQ_ACK` -> IDLE and `retry_cnt`=0.

Outputs are decodes of the registered state:
- `RETRY` = (state==RETRY_ST).
- `IRQ_PENDING` = (state==PENDING).
- `ERROR` = (state==ERROR_ST).

## Timing
Reset:
- `RESETN` low forces, immediately and asynchronously:
  - state=IDLE;
  - all counters, `irq_s` and `irq_s_d` to 0;
  - `RETRY`, `IRQ_PENDING`, `ERROR` = 0 and `IRQ_COUNT` = 0.
- A reset mid-PENDING or mid-QUALIFY drops the interrupt without counting it.

Qualification latency:
- First edge sampling `IRQ_IN` high is k.
- With effective width N≥1 and `IRQ_IN` high at edges k..k+N-1, PENDING is entered at edge k+N.
- `IRQ_PENDING` is therefore high from edge k+N.

Timeout:
- PENDING entered at edge p with no ACK leaves at edge p+`TIMEOUT`.
- `RETRY` is then high for exactly cycle p+`TIMEOUT`..p+`TIMEOUT`+1.

Priority and boundary cases:
- ACK at the same edge as timeout expiry: ACK wins, no retry.
- `RETRY_LIMIT`=0: the first timeout goes straight to ERROR_ST.
- A parameter or input change mid-count takes effect on the next comparison.
- No cycle-level constraint on `IRQ_ACK` width. Holding ACK high keeps IDLE ignoring it, and PENDING exits on its first sampled cycle.

## Structure
- Package `mp_irq_pkg`: state enum (IDLE_ST, QUALIFY_ST, PENDING_ST, RETRY_ST, ERROR_ST) and width localparams. This package is shared with future edits of the generator.
- One sub-module, `mp_irq_edge_detect`: sample register plus rising-edge pulse, parameterised on reset value.
- Remaining logic in a single FSM block plus counter blocks.

## Test plan
- `MIN_WIDTH`=4: drive `IRQ_IN` high 3 cycles -> no PENDING, `IRQ_COUNT`=0. Then drive 4 cycles -> PENDING at edge k+4, `IRQ_COUNT`=1.
- `TIMEOUT`=10, ACK at 5 cycles after PENDING -> IDLE, `RETRY` never pulses, `retry_cnt` cleared.
- Loop with the generator, `DURATION`=20, `TIMEOUT`=8, `RETRY_LIMIT`=2, no ACK:
  - 2 `RETRY` pulses, each 1 cycle wide, each triggering a new generator pulse;
  - `IRQ_COUNT`=3, then ERROR=1 until ACK.
- ACK asserted on the exact expiry edge (`TIMEOUT`=6, ACK at p+6) -> IDLE, no `RETRY`.
- Second `IRQ_IN` pulse during PENDING -> `IRQ_COUNT` unchanged. `TIMEOUT`=0 -> PENDING held 1000 cycles with no `RETRY`.
- Assert `RESETN` low mid-PENDING and asynchronously between edges -> outputs 0 immediately. After release, `IRQ_COUNT`=0 and state=IDLE.
